wb_regbank_n: RTL and testbench
===============================

# wb_regbank_n

Parametrised Wishbone classic/pipelined slave register bank: NREGS 32-bit control registers with byte-lane write enables, optional read-only status slots, and per-register write strobes. Successor to the fixed three-register banks; it sits behind the Wishbone interconnect and drives control outputs into user logic. Write and read paths are registered once for timing closure.

## Interface
- NREGS, 3, number of 32-bit register slots (1..64)
- ADR_W, 2, word-address width; must satisfy 2**ADR_W >= NREGS
- RO_MASK, 0, bit i set: slot i is read-only and reads status_i slice i
- RST_VAL, 32'h0, reset value of every read/write register
- clk_i  in  1  system clock, all logic on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- wb_cyc_i, wb_stb_i, wb_we_i  in  1  Wishbone cycle/strobe/write-enable
- wb_adr_i  in  [ADR_W+1:2]  word address
- wb_sel_i  in  4  byte-lane select
- wb_dat_i  in  32  write data
- wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o  out  1  Wishbone responses
- wb_dat_o  out  32  read data (registered)
- regs_o  out  NREGS*32  register contents, slot i at [32i+31:32i]; read-only slots drive 0
- wr_strobe_o  out  NREGS  one-cycle pulse when slot i is written
- status_i  in  NREGS*32  status inputs for read-only slots; ignored for RW slots

## Operation
- wb_en = cyc & stb. Read request accepted when wb_en & ~we & ~rd_in_progress; write request when wb_en & we & ~wr_in_progress. In-progress flags set on acceptance and clear on the corresponding ack.
- Write path: request, address, data and sel registered into stage d0. From d0, address decode raises slot wreq; on next edge the slot updates its bytes where sel[k]=1 (bits [8k+7:8k]); unselected bytes keep value. Slot wack registered from wreq; wb_ack_o = wack of addressed slot.
- Read path: combinational decode of wb_adr_i; read data and ack registered into wb_dat_o / wb_ack_o. RW slot returns register value; RO slot returns status_i slice (sampled at request cycle).
- Write to RO slot: acknowledged, no state change, no strobe.
- Unmapped address (>= NREGS): acknowledged; read data 0; write discarded.
- wb_stall_o = ~(ack|err) & wb_en. wb_rty_o = 0 constant.
- Reset: regs = RST_VAL, wb_dat_o = 0, all ack/err/strobe/d0/in-progress = 0. Reset mid-transaction drops it: no ack is issued after reset release for the aborted request.

## Timing
- Read: request in cycle T, wb_ack_o and wb_dat_o valid in cycle T+1, latency 1.
- Write: request in cycle T, register value on regs_o and wr_strobe_o pulse in cycle T+2, wb_ack_o in cycle T+2, latency 2.
- Held request (stb kept high) is accepted once; next transaction accepted the cycle after ack.
- Ack, err each exactly one cycle, never both.

## Configuration
- WB_REGBANK_ERR_EN defined: accesses to unmapped addresses and writes to RO slots answer with wb_err_o (same latency as ack) instead of wb_ack_o; read data 0.
- Undefined: wb_err_o tied 0; such accesses acked as described above.

## Test plan
- Reset, NREGS=3, RST_VAL=32'hA5A5_0000: read slots 0..2 -> 32'hA5A5_0000 each, ack one cycle after request, err 0.
- Write 32'h1234_5678 sel=4'b0101 to slot 1 from 32'h0 -> regs_o slot1 = 32'h0034_0078, wr_strobe_o[1] pulse in T+2, ack in T+2.
- RO_MASK=3'b100, status_i slot2 = 32'hDEAD_BEEF: read slot 2 -> 32'hDEAD_BEEF; write slot 2 -> no strobe, value unchanged, ack (err with WB_REGBANK_ERR_EN).
- Read address 3 (unmapped) -> data 0, ack; with WB_REGBANK_ERR_EN -> err, ack 0.
- Hold stb high for 5 cycles on a write -> exactly one ack, one strobe; stall high until ack.
- Assert rst_n_i low in cycle T+1 of a write -> no ack after release, regs_o = RST_VAL.

Source files
------------

// File: rtl/wb_regbank_n.sv
// wb_regbank_n: Wishbone slave bank of NREGS 32-bit control registers with
// byte-lane writes, optional read-only status slots and per-slot write strobes.
// Reads answer one cycle after the request. Writes pass through one staging
// register (d0) and answer two cycles after the request.
// Optional feature macro: WB_REGBANK_ERR_EN. When defined, unmapped accesses
// and writes to read-only slots answer with wb_err_o instead of wb_ack_o.
module wb_regbank_n #(
  parameter int unsigned      NREGS   = 3,
  parameter int unsigned      ADR_W   = 2,
  parameter logic [NREGS-1:0] RO_MASK = '0,
  parameter logic [31:0]      RST_VAL = 32'h0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADR_W+1:2]    wb_adr_i,
  input  logic [3:0]          wb_sel_i,
  input  logic [31:0]         wb_dat_i,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_rty_o,
  output logic                wb_stall_o,
  output logic [31:0]         wb_dat_o,
  output logic [NREGS*32-1:0] regs_o,
  output logic [NREGS-1:0]    wr_strobe_o,
  input  logic [NREGS*32-1:0] status_i
);

`ifdef WB_REGBANK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic wb_en, rd_req, wr_req, rd_acc, wr_acc, rd_done, wr_done;

  // A request that stays asserted after its response is treated as the same
  // transaction (hold flags), so a master that is slow to drop stb is not
  // serviced twice.
  logic rd_busy_q, rd_hold_q, wr_busy_q, wr_hold_q;

  logic                d0_vld_q;
  logic [ADR_W+1:2]    d0_adr_q;
  logic [31:0]         d0_dat_q;
  logic [3:0]          d0_sel_q;

  logic [NREGS-1:0]    wreq_d;
  logic                werr_d;
  logic [31:0]         regs_q [NREGS];
  logic [NREGS-1:0]    wr_strobe_q;
  logic                wr_ack_q, wr_err_q;

  logic [31:0]         rd_dat_d;
  logic                rd_err_d;
  logic                rd_ack_q, rd_err_q;
  logic [31:0]         rd_dat_q;

  assign wb_en   = wb_cyc_i & wb_stb_i;
  assign rd_req  = wb_en & ~wb_we_i;
  assign wr_req  = wb_en & wb_we_i;
  assign rd_acc  = rd_req & ~rd_busy_q & ~rd_hold_q;
  assign wr_acc  = wr_req & ~wr_busy_q & ~wr_hold_q;
  assign rd_done = rd_ack_q | rd_err_q;
  assign wr_done = wr_ack_q | wr_err_q;

  // Read decode straight off the bus address; RO slots return live status.
  always_comb begin
    rd_dat_d = '0;
    rd_err_d = ERR_EN;
    for (int i = 0; i < NREGS; i++) begin
      if (wb_adr_i == ADR_W'(i)) begin
        rd_dat_d = RO_MASK[i] ? status_i[32*i +: 32] : regs_q[i];
        rd_err_d = 1'b0;
      end
    end
  end

  // Write decode from the d0 stage: per-slot write request and error class.
  always_comb begin
    wreq_d = '0;
    werr_d = ERR_EN;
    for (int i = 0; i < NREGS; i++) begin
      if (d0_adr_q == ADR_W'(i)) begin
        wreq_d[i] = d0_vld_q & ~RO_MASK[i];
        werr_d    = ERR_EN & RO_MASK[i];
      end
    end
  end

  // Write staging data: captured on acceptance, needs no reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      d0_adr_q <= wb_adr_i;
      d0_dat_q <= wb_dat_i;
      d0_sel_q <= wb_sel_i;
    end
  end

  // Register slots: byte-lane update on the slot write request.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= RST_VAL;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (wreq_d[i] && d0_sel_q[k]) regs_q[i][8*k +: 8] <= d0_dat_q[8*k +: 8];
        end
      end
    end
  end

  // Handshake control, response flags, strobes and registered read data.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_busy_q   <= 1'b0;
      rd_hold_q   <= 1'b0;
      wr_busy_q   <= 1'b0;
      wr_hold_q   <= 1'b0;
      d0_vld_q    <= 1'b0;
      wr_strobe_q <= '0;
      wr_ack_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_dat_q    <= '0;
    end else begin
      if (rd_acc)       rd_busy_q <= 1'b1;
      else if (rd_done) rd_busy_q <= 1'b0;
      if (rd_done)      rd_hold_q <= rd_req;
      else              rd_hold_q <= rd_hold_q & rd_req;
      if (wr_acc)       wr_busy_q <= 1'b1;
      else if (wr_done) wr_busy_q <= 1'b0;
      if (wr_done)      wr_hold_q <= wr_req;
      else              wr_hold_q <= wr_hold_q & wr_req;
      d0_vld_q    <= wr_acc;
      wr_strobe_q <= wreq_d;
      wr_ack_q    <= d0_vld_q & ~werr_d;
      wr_err_q    <= d0_vld_q & werr_d;
      rd_ack_q    <= rd_acc & ~rd_err_d;
      rd_err_q    <= rd_acc & rd_err_d;
      if (rd_acc) rd_dat_q <= rd_dat_d;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_out
    assign regs_o[32*g +: 32] = RO_MASK[g] ? 32'h0 : regs_q[g];
  end

  assign wb_ack_o    = rd_ack_q | wr_ack_q;
  assign wb_err_o    = rd_err_q | wr_err_q;
  assign wb_rty_o    = 1'b0;
  assign wb_stall_o  = ~(wb_ack_o | wb_err_o) & wb_en;
  assign wb_dat_o    = rd_dat_q;
  assign wr_strobe_o = wr_strobe_q;

endmodule

// File: tb/tb_wb_regbank_n.sv
// tb_wb_regbank_n: directed bench for wb_regbank_n (NREGS=3, slot 2 read-only,
// RST_VAL=32'hA5A5_0000). Expected responses are queued when a request is
// driven and popped when the slave answers.
module tb_wb_regbank_n;
  localparam logic [2:0]  RO = 3'b100;
  localparam logic [31:0] RV = 32'hA5A5_0000;
`ifdef WB_REGBANK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, cyc, stb, we;
  logic [3:2]  adr;
  logic [3:0]  sel;
  logic [31:0] dat_w, dat_r;
  logic        ack, err, rty, stall;
  logic [95:0] regs, status;
  logic [2:0]  strobe;

  typedef struct {logic err; logic [31:0] dat; bit chk;} exp_t;
  exp_t        sbq[$];
  logic [31:0] mdl [3];
  int          ncmp = 0;
  int          nfail = 0;

  always #5 clk = ~clk;

  wb_regbank_n #(.NREGS(3), .ADR_W(2), .RO_MASK(3'b100), .RST_VAL(32'hA5A5_0000)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_w), .wb_ack_o(ack), .wb_err_o(err),
    .wb_rty_o(rty), .wb_stall_o(stall), .wb_dat_o(dat_r), .regs_o(regs),
    .wr_strobe_o(strobe), .status_i(status)
  );

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] exp_regs();
    logic [95:0] v;
    for (int i = 0; i < 3; i++) v[32*i +: 32] = RO[i] ? 32'h0 : mdl[i];
    return v;
  endfunction

  task automatic respond(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, (sbq.size() != 0), 1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check({tag, "_err"}, err, e.err);
      check({tag, "_ack"}, ack, !e.err);
      if (e.chk) check({tag, "_data"}, dat_r, e.dat);
    end
  endtask

  task automatic wait_resp(input string tag, input int exp_lat);
    int lat = 0;
    bit got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      if (ack | err) got = 1'b1;
      else begin
        check({tag, "_stall_wait"}, stall, 1);
        lat++;
      end
    end
    check({tag, "_timeout"}, got, 1);
    if (got) begin
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_stall_resp"}, stall, 0);
      respond(tag);
    end
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check({tag, "_resp_clear"}, {ack, err}, 2'b00);
    check({tag, "_strobe_clear"}, strobe, 3'b000);
  endtask

  task automatic do_read(input logic [1:0] a, input string tag);
    exp_t e;
    e.err = ERR_EN && (a >= 2'd3);
    e.dat = (a >= 2'd3) ? 32'h0 : (RO[a] ? status[32*a +: 32] : mdl[a]);
    e.chk = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    sbq.push_back(e);
    wait_resp(tag, 1);
    idle_check(tag);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input string tag);
    exp_t e;
    bit ok;
    logic [2:0] sm;
    ok    = (a < 2'd3) ? !RO[a] : 1'b0;
    e.err = ERR_EN && !ok;
    e.dat = 32'h0;
    e.chk = 1'b0;
    sm    = ok ? (3'b001 << a) : 3'b000;
    if (ok) for (int k = 0; k < 4; k++) if (s[k]) mdl[a][8*k +: 8] = d[8*k +: 8];
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; sel = s; dat_w = d;
    sbq.push_back(e);
    wait_resp(tag, 2);
    check({tag, "_strobe"}, strobe, sm);
    check({tag, "_regs"}, regs, exp_regs());
    idle_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int   nack, nstb, nresp;
    exp_t eh;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat_w = '0;
    status = {32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
    for (int i = 0; i < 3; i++) mdl[i] = RV;
    repeat (2) @(negedge clk);
    check("rst_regs", regs, {32'h0, RV, RV});
    check("rst_resp", {ack, err, rty}, 3'b000);
    check("rst_strobe", strobe, 3'b000);
    check("rst_dat", dat_r, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    do_read(2'd0, "rd0_rst");
    do_read(2'd1, "rd1_rst");
    do_read(2'd2, "rd2_status");
    do_write(2'd1, 32'h0000_0000, 4'hF, "wr1_clear");
    do_write(2'd1, 32'h1234_5678, 4'b0101, "wr1_partial");
    check("slot1_partial", regs[63:32], 32'h0034_0078);
    do_read(2'd1, "rd1_partial");
    do_write(2'd0, 32'hFFFF_FFFF, 4'b1000, "wr0_byte3");
    check("slot0_byte3", regs[31:0], 32'hFFA5_0000);
    do_write(2'd2, 32'h3333_3333, 4'hF, "wr2_ro");
    check("slot2_ro_zero", regs[95:64], 32'h0);
    do_read(2'd2, "rd2_after_wr");
    do_read(2'd3, "rd_unmapped");
    do_write(2'd3, 32'h4444_4444, 4'hF, "wr_unmapped");
    check("rty_zero", rty, 1'b0);

    // held write request: one response, one strobe
    mdl[0][7:0] = 8'hAB;
    eh = '{err: 1'b0, dat: 32'h0, chk: 1'b0};
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd0; sel = 4'b0001; dat_w = 32'h0000_00AB;
    sbq.push_back(eh);
    nack = 0; nstb = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("hold_stall_c%0d", c), stall, (c < 5 && c != 2));
      if (ack | err) begin nack++; respond("hold"); end
      if (strobe[0]) nstb++;
      if (c == 4) begin @(posedge clk); #1; cyc = 1'b0; stb = 1'b0; we = 1'b0; end
    end
    check("hold_acks", nack, 1);
    check("hold_strobes", nstb, 1);
    check("hold_slot0", regs[31:0], 32'hFFA5_00AB);

    // reset in the cycle after a write request aborts it
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd1; sel = 4'hF; dat_w = 32'hCAFE_F00D;
    @(posedge clk); #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) mdl[i] = RV;
    @(negedge clk);
    check("midrst_regs", regs, exp_regs());
    check("midrst_dat", dat_r, 32'h0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; rst_n = 1'b1;
    nresp = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack | err) nresp++;
      if (strobe != 3'b000) nresp++;
    end
    check("midrst_no_resp", nresp, 0);
    check("midrst_regs_after", regs, {32'h0, RV, RV});
    do_read(2'd1, "rd1_after_rst");
    check("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
